// File: rtl/xgmii_rx_monitor.sv
// Inline XGMII receive monitor: one-cycle passthrough plus /S/ /T/ /E/ parsing
// that produces a per-frame close pulse and saturating frame/byte/error/runt counters.
module xgmii_rx_monitor #(
  parameter int CNT_W   = 32,
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_xgmii_ctrl,
  input  logic [63:0]      in_xgmii_data,
  output logic [7:0]       out_xgmii_ctrl,
  output logic [63:0]      out_xgmii_data,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] runt_count
);

  localparam logic [7:0]  CODE_S    = 8'hFB;
  localparam logic [7:0]  CODE_T    = 8'hFD;
  localparam logic [7:0]  CODE_E    = 8'hFE;
  localparam logic [63:0] IDLE_WORD = {8{8'h07}};

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t           state;
  logic [LEN_W-1:0] acc;
  logic             err_flag;

  function automatic logic [LEN_W-1:0] len_add(input logic [LEN_W-1:0] a,
                                               input logic [3:0]       b);
    logic [LEN_W:0] s;
    s = {1'b0, a} + (LEN_W+1)'(b);
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  // Strip the 7 preamble/SFD bytes counted from the /S/ lane onward.
  function automatic logic [LEN_W-1:0] len_of(input logic [LEN_W-1:0] a);
    return (a >= LEN_W'(7)) ? a - LEN_W'(7) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Per-word lane decode.
  logic [7:0]       is_s, is_t, is_e, bad, before_t;
  logic             s_hit, t_hit, bad_hit, e_before;
  logic [2:0]       s_lane, t_lane, bad_lane;
  logic [LEN_W-1:0] t_len, abort_len;
  logic             t_err, restart_after_t, restart_after_abort;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_s     = '0;
    is_t     = '0;
    is_e     = '0;
    s_lane   = '0;
    t_lane   = '0;
    bad_lane = '0;
    for (int i = 0; i < 8; i++) begin
      is_s[i] = in_xgmii_ctrl[i] && (in_xgmii_data[8*i +: 8] == CODE_S);
      is_t[i] = in_xgmii_ctrl[i] && (in_xgmii_data[8*i +: 8] == CODE_T);
      is_e[i] = in_xgmii_ctrl[i] && (in_xgmii_data[8*i +: 8] == CODE_E);
    end
    t_hit = |is_t;
    s_hit = |is_s;
    // Descending scan leaves the lowest matching lane.
    for (int i = 7; i >= 0; i--) begin
      if (is_t[i]) t_lane = 3'(i);
      if (is_s[i]) s_lane = 3'(i);
    end
    before_t = t_hit ? ((8'd1 << t_lane) - 8'd1) : 8'hFF;
    bad      = in_xgmii_ctrl & ~is_t & ~is_e & before_t;
    bad_hit  = |bad;
    for (int i = 7; i >= 0; i--) begin
      if (bad[i]) bad_lane = 3'(i);
    end
    e_before            = |(is_e & before_t);
    t_len               = len_of(len_add(acc, {1'b0, t_lane}));
    t_err               = err_flag | e_before;
    abort_len           = len_of(len_add(acc, {1'b0, bad_lane}));
    restart_after_t     = (t_lane < 3'd4) && is_s[4];
    restart_after_abort = is_s[bad_lane] && ((bad_lane == 3'd0) || (bad_lane == 3'd4));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_xgmii_ctrl <= 8'hFF;
      out_xgmii_data <= IDLE_WORD;
      frame_done     <= 1'b0;
      frame_len      <= '0;
      frame_err      <= 1'b0;
      frame_count    <= '0;
      byte_count     <= '0;
      err_count      <= '0;
      runt_count     <= '0;
      state          <= IDLE;
      acc            <= '0;
      err_flag       <= 1'b0;
    end else begin
      out_xgmii_ctrl <= in_xgmii_ctrl;
      out_xgmii_data <= in_xgmii_data;
      frame_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (s_hit) begin
            if ((s_lane == 3'd0) || (s_lane == 3'd4)) begin
              state    <= IN_FRAME;
              acc      <= (s_lane == 3'd0) ? LEN_W'(7) : LEN_W'(3);
              err_flag <= 1'b0;
            end else begin
              err_count <= cnt_add(err_count, CNT_W'(1));
            end
          end
        end
        IN_FRAME: begin
          if (bad_hit) begin
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
            frame_len  <= abort_len;
            err_count  <= cnt_add(err_count, CNT_W'(1));
            err_flag   <= 1'b0;
            if (restart_after_abort) acc <= (bad_lane == 3'd0) ? LEN_W'(7) : LEN_W'(3);
            else                     state <= IDLE;
          end else if (t_hit) begin
            frame_done <= 1'b1;
            frame_len  <= t_len;
            err_flag   <= 1'b0;
            if (t_err) begin
              frame_err <= 1'b1;
              err_count <= cnt_add(err_count, CNT_W'(1));
            end else if (t_len < LEN_W'(MIN_LEN)) begin
              frame_err  <= 1'b0;
              runt_count <= cnt_add(runt_count, CNT_W'(1));
            end else if (t_len > LEN_W'(MAX_LEN)) begin
              frame_err <= 1'b1;
              err_count <= cnt_add(err_count, CNT_W'(1));
            end else begin
              frame_err   <= 1'b0;
              frame_count <= cnt_add(frame_count, CNT_W'(1));
              byte_count  <= cnt_add(byte_count, CNT_W'(t_len));
            end
            if (restart_after_t) acc   <= LEN_W'(3);
            else                 state <= IDLE;
          end else begin
            acc      <= len_add(acc, 4'd8);
            err_flag <= err_flag | e_before;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_rx_monitor.sv
// Directed bench for xgmii_rx_monitor: stimulus pushes expected close pulses into a
// scoreboard queue, a monitor pops them whenever frame_done is seen.
module tb_xgmii_rx_monitor;

  localparam logic [63:0] IDLE_D = {8{8'h07}};

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [63:0] in_data, out_data;
  logic        frame_done, frame_err;
  logic [15:0] frame_len;
  logic [31:0] frame_count, byte_count, err_count, runt_count;

  typedef struct packed {
    logic [15:0] len;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  xgmii_rx_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .in_xgmii_ctrl (in_ctrl),
    .in_xgmii_data (in_data),
    .out_xgmii_ctrl(out_ctrl),
    .out_xgmii_data(out_data),
    .frame_done    (frame_done),
    .frame_len     (frame_len),
    .frame_err     (frame_err),
    .frame_count   (frame_count),
    .byte_count    (byte_count),
    .err_count     (err_count),
    .runt_count    (runt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string tag, input int fc, input int bc,
                                input int ec, input int rc);
    check({tag, "_frame_count"}, 64'(frame_count), 64'(fc));
    check({tag, "_byte_count"},  64'(byte_count),  64'(bc));
    check({tag, "_err_count"},   64'(err_count),   64'(ec));
    check({tag, "_runt_count"},  64'(runt_count),  64'(rc));
  endtask

  // Drive at the negedge; the following posedge samples it.
  task automatic word(input logic [7:0] c, input logic [63:0] d);
    in_ctrl = c;
    in_data = d;
    @(negedge clk);
  endtask

  task automatic idle_word();
    word(8'hFF, IDLE_D);
  endtask

  task automatic data_words(input int n);
    for (int i = 0; i < n; i++) word(8'h00, {32'hA5A5_0000 + 32'(i), 32'h1234_5678});
  endtask

  task automatic start0();
    word(8'h01, 64'hD555_5555_5555_55FB);
  endtask

  task automatic start4();
    word(8'h1F, 64'h5555_55FB_0707_0707);
  endtask

  task automatic term(input int t);
    logic [7:0]  c;
    logic [63:0] d;
    for (int i = 0; i < 8; i++) begin
      if (i < t)       begin c[i] = 1'b0; d[8*i +: 8] = 8'h33; end
      else if (i == t) begin c[i] = 1'b1; d[8*i +: 8] = 8'hFD; end
      else             begin c[i] = 1'b1; d[8*i +: 8] = 8'h07; end
    end
    word(c, d);
  endtask

  task automatic expect_pulse(input int len, input logic err);
    exp_t e;
    e.len = 16'(len);
    e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: passthrough/reset image and scoreboard pops on frame_done.
  initial begin
    logic [7:0]  pc;
    logic [63:0] pd;
    logic        pr;
    exp_t        e;
    forever begin
      @(posedge clk);
      pc = in_ctrl;
      pd = in_data;
      pr = reset;
      @(negedge clk);
      if (!pr) begin
        check("reset_out_ctrl", 64'(out_ctrl), 64'hFF);
        check("reset_out_data", out_data, IDLE_D);
        check("reset_frame_done", 64'(frame_done), 64'h0);
      end else begin
        check("pass_ctrl", 64'(out_ctrl), 64'(pc));
        check("pass_data", out_data, pd);
      end
      if (frame_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got len %0d err %0b expected no pulse",
                   frame_len, frame_err);
        end else begin
          e = sb.pop_front();
          check("frame_len", 64'(frame_len), 64'(e.len));
          check("frame_err", 64'(frame_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    reset   = 1'b0;
    in_ctrl = 8'hFF;
    in_data = IDLE_D;
    @(negedge clk);
    @(negedge clk);
    check_counters("reset", 0, 0, 0, 0);
    check("reset_len", 64'(frame_len), 64'h0);
    reset = 1'b1;
    idle_word();

    // 64-byte frame, /S/ lane 0, /T/ lane 0
    start0(); data_words(8); expect_pulse(64, 1'b0); term(0); idle_word();
    check_counters("good_lane0", 1, 64, 0, 0);

    // 64-byte frame, /S/ lane 4, /T/ lane 4
    start4(); data_words(8); expect_pulse(64, 1'b0); term(4); idle_word();
    check_counters("good_lane4", 2, 128, 0, 0);

    // 35-byte runt
    start0(); data_words(4); expect_pulse(35, 1'b0); term(3); idle_word();
    check_counters("runt", 2, 128, 0, 1);

    // /E/ mid-frame, then /T/ lane 2 with /S/ lane 4 in the same word, then 64-byte frame
    start0(); data_words(3);
    word(8'h20, 64'h1111_FE11_1111_1111);
    data_words(3);
    expect_pulse(58, 1'b1);
    word(8'h1C, 64'h5555_55FB_07FD_3333);
    data_words(8); expect_pulse(64, 1'b0); term(4); idle_word();
    check_counters("err_b2b", 3, 192, 1, 1);

    // Reset mid-frame discards the partial frame
    start0(); data_words(3);
    reset = 1'b0;
    idle_word(); idle_word();
    reset = 1'b1;
    idle_word();
    check_counters("mid_reset", 0, 0, 0, 0);
    start0(); data_words(8); expect_pulse(64, 1'b0); term(0); idle_word();
    check_counters("after_reset", 1, 64, 0, 0);

    // /S/ on illegal lane 2 while idle
    word(8'h04, 64'h5555_5555_55FB_0707); idle_word();
    check_counters("bad_start", 1, 64, 1, 0);

    // /T/ and /E/ while idle are ignored
    term(3); word(8'hFF, 64'h0707_0707_0707_07FE); idle_word();
    check_counters("idle_ctrl", 1, 64, 1, 0);

    // Mid-frame /S/ on lane 0 aborts (len 16) and restarts a good frame
    start0(); data_words(2);
    expect_pulse(16, 1'b1); start0();
    data_words(8); expect_pulse(64, 1'b0); term(0); idle_word();
    check_counters("abort", 2, 128, 2, 0);

    // Exactly MAX_LEN is good
    start0(); data_words(189); expect_pulse(1518, 1'b0); term(6); idle_word();
    check_counters("max_len", 3, 1646, 2, 0);

    // MAX_LEN+2 is jabber
    start0(); data_words(190); expect_pulse(1520, 1'b1); term(0); idle_word();
    check_counters("jabber", 3, 1646, 3, 0);

    // MIN_LEN-1 is a runt
    start0(); data_words(7); expect_pulse(63, 1'b0); term(7); idle_word();
    check_counters("min_minus1", 3, 1646, 3, 1);

    idle_word(); idle_word();
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
